// File: rtl/key_load_ctrl_pkg.sv
// Shared types, default constants and counter sizing for the key loader.
package key_load_pkg;

  typedef enum logic [2:0] {
    KL_IDLE  = 3'd0,
    KL_LOAD  = 3'd1,
    KL_CHECK = 3'd2,
    KL_ARMED = 3'd3,
    KL_ERROR = 3'd4
  } kl_state_t;

  localparam int KL_KEY_W_DEF   = 32;
  localparam int KL_TIMEOUT_DEF = 255;

  function automatic int kl_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/key_load_ctrl_if.sv
// Key store handshake plus locked-core key/enable bus for key_load_ctrl.
interface key_load_ctrl_if
  import key_load_pkg::*;
#(
  parameter int KEY_W = KL_KEY_W_DEF
);
  logic             start;
  logic             key_req;
  logic             key_ack;
  logic             key_bit;
  logic [KEY_W-1:0] keyinput;
  logic             core_en;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, key_ack, key_bit,
    input  key_req, keyinput, core_en, busy, done, err
  );

  modport slave (
    input  start, key_ack, key_bit,
    output key_req, keyinput, core_en, busy, done, err
  );
endinterface

// File: rtl/key_load_ctrl_shift_reg.sv
// Shadow shift register: LSB-first serial fill, running parity, parallel read-out.
module key_shift_reg #(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [KEY_W-1:0] q,
  output logic             par
);

  logic [KEY_W-1:0] sh_q, sh_d;
  logic [KEY_W:0]   sh_ext_s;
  logic             par_q, par_d;

  function automatic logic par_next(input logic p, input logic b);
    return p ^ b;
  endfunction

  assign sh_ext_s = {bit_in, sh_q};

  // Next shadow contents and parity; new bits enter at the top and walk down.
  always_comb begin
    sh_d  = sh_q;
    par_d = par_q;
    if (clr) begin
      sh_d  = {KEY_W{1'b0}};
      par_d = 1'b0;
    end else if (shift_en) begin
      sh_d  = sh_ext_s[KEY_W:1];
      par_d = par_next(par_q, bit_in);
    end else begin
      sh_d  = sh_q;
      par_d = par_q;
    end
  end

  // Shadow and parity registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= {KEY_W{1'b0}};
      par_q <= 1'b0;
    end else begin
      sh_q  <= sh_d;
      par_q <= par_d;
    end
  end

  assign q   = sh_q;
  assign par = par_q;

endmodule

// File: rtl/key_load_ctrl.sv
// Serial logic-locking key loader; applies a key atomically once received and checked.
// Define KEY_LOAD_PARITY_EN to add an even-parity beat checked before arming.
module key_load_ctrl
  import key_load_pkg::*;
#(
  parameter int KEY_W   = KL_KEY_W_DEF,
  parameter int TIMEOUT = KL_TIMEOUT_DEF
) (
  input logic            CK,
  input logic            RN,
  key_load_ctrl_if.slave bus
);

`ifdef KEY_LOAD_PARITY_EN
  localparam int BEATS = KEY_W + 1;
`else
  localparam int BEATS = KEY_W;
`endif
  localparam int BC_W = kl_cnt_w(BEATS);
  localparam int TO_W = kl_cnt_w(TIMEOUT);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEATS - 1);
  localparam logic [BC_W-1:0] BC_DATA = BC_W'(KEY_W);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  kl_state_t        state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [KEY_W-1:0] keyinput_q, keyinput_d;
  logic             key_req_q, key_req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             core_en_q, core_en_d;
  logic             err_q, err_d;

  logic             ack_s, last_beat_s, timeout_s, load_entry_s, shift_en_s;
  logic             check_pass_s;
  logic [KEY_W-1:0] shadow_s;
  logic             shadow_par_s;

  assign ack_s        = (state_q == KL_LOAD) && bus.key_ack;
  assign last_beat_s  = ack_s && (bit_cnt_q == BC_LAST);
  assign timeout_s    = (state_q == KL_LOAD) && !bus.key_ack && (to_cnt_q == TO_LAST);
  assign load_entry_s = (state_d == KL_LOAD) && (state_q != KL_LOAD);
  assign shift_en_s   = ack_s && (bit_cnt_q < BC_DATA);

  key_shift_reg #(.KEY_W(KEY_W)) u_shadow (
    .clk      (CK),
    .rst_n    (RN),
    .clr      (load_entry_s),
    .shift_en (shift_en_s),
    .bit_in   (bus.key_bit),
    .q        (shadow_s),
    .par      (shadow_par_s)
  );

`ifdef KEY_LOAD_PARITY_EN
  logic par_bit_q, par_bit_d;

  // Capture the beat that follows the last data bit.
  always_comb begin
    par_bit_d = par_bit_q;
    if (load_entry_s) begin
      par_bit_d = 1'b0;
    end else if (ack_s && (bit_cnt_q == BC_DATA)) begin
      par_bit_d = bus.key_bit;
    end else begin
      par_bit_d = par_bit_q;
    end
  end

  // Received parity bit register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) par_bit_q <= 1'b0;
    else     par_bit_q <= par_bit_d;
  end

  assign check_pass_s = (par_bit_q == shadow_par_s);
`else
  logic unused_par_s;
  assign unused_par_s = shadow_par_s;
  assign check_pass_s = 1'b1;
`endif

  // State register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) state_q <= KL_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; an ack on the expiry cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      KL_IDLE: begin
        if (bus.start) state_d = KL_LOAD;
        else           state_d = KL_IDLE;
      end
      KL_LOAD: begin
        if (last_beat_s)    state_d = KL_CHECK;
        else if (timeout_s) state_d = KL_ERROR;
        else                state_d = KL_LOAD;
      end
      KL_CHECK: begin
        if (check_pass_s) state_d = KL_ARMED;
        else              state_d = KL_ERROR;
      end
      KL_ARMED: begin
        if (bus.start) state_d = KL_LOAD;
        else           state_d = KL_ARMED;
      end
      KL_ERROR: begin
        if (bus.start) state_d = KL_LOAD;
        else           state_d = KL_ERROR;
      end
      default: state_d = KL_IDLE;
    endcase
  end

  // Beat and idle-cycle counters, both restarted on every entry to LOAD.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    if (load_entry_s) begin
      bit_cnt_d = {BC_W{1'b0}};
      to_cnt_d  = {TO_W{1'b0}};
    end else if (ack_s) begin
      bit_cnt_d = bit_cnt_q + BC_W'(1);
      to_cnt_d  = {TO_W{1'b0}};
    end else if (state_q == KL_LOAD) begin
      to_cnt_d  = to_cnt_q + TO_W'(1);
    end else begin
      bit_cnt_d = bit_cnt_q;
      to_cnt_d  = to_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      bit_cnt_q <= {BC_W{1'b0}};
      to_cnt_q  <= {TO_W{1'b0}};
    end else begin
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Outputs follow the next state so they are valid in the cycle the state is entered.
  always_comb begin
    key_req_d = (state_d == KL_LOAD);
    busy_d    = (state_d == KL_LOAD) || (state_d == KL_CHECK);
    done_d    = (state_d == KL_ARMED);
    core_en_d = (state_d == KL_ARMED);
    err_d     = (state_d == KL_ERROR);
    if ((state_q == KL_CHECK) && (state_d == KL_ARMED)) begin
      keyinput_d = shadow_s;
    end else if (state_d == KL_ARMED) begin
      keyinput_d = keyinput_q;
    end else begin
      keyinput_d = {KEY_W{1'b0}};
    end
  end

  // Output registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      keyinput_q <= {KEY_W{1'b0}};
      key_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      core_en_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      keyinput_q <= keyinput_d;
      key_req_q  <= key_req_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      core_en_q  <= core_en_d;
      err_q      <= err_d;
    end
  end

  assign bus.keyinput = keyinput_q;
  assign bus.key_req  = key_req_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.core_en  = core_en_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl with KEY_W=8, TIMEOUT=4; honours KEY_LOAD_PARITY_EN.
module tb_key_load_ctrl;
  import key_load_pkg::*;

  localparam int KW = 8;
  localparam int TO = 4;

  logic CK = 1'b0;
  logic RN = 1'b0;
  int   checks = 0;
  int   failures = 0;

  key_load_ctrl_if #(.KEY_W(KW)) bus ();

  key_load_ctrl #(.KEY_W(KW), .TIMEOUT(TO)) dut (
    .CK  (CK),
    .RN  (RN),
    .bus (bus)
  );

  always #5 CK = ~CK;

  typedef struct {
    logic [7:0] key;       // key[0] is sent first
    int         gap_at;    // ack withheld before this bit index (-1: never)
    int         gap_len;   // number of no-ack cycles
    logic       par_flip;  // corrupt the parity beat (parity build only)
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_key;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic req, input logic bsy,
                          input logic dn, input logic ce, input logic er, input logic [7:0] key);
    chk({tag, ".key_req"},  {31'd0, bus.key_req}, {31'd0, req});
    chk({tag, ".busy"},     {31'd0, bus.busy},    {31'd0, bsy});
    chk({tag, ".done"},     {31'd0, bus.done},    {31'd0, dn});
    chk({tag, ".core_en"},  {31'd0, bus.core_en}, {31'd0, ce});
    chk({tag, ".err"},      {31'd0, bus.err},     {31'd0, er});
    chk({tag, ".keyinput"}, {24'd0, bus.keyinput}, {24'd0, key});
  endtask

  // Called at a negedge; returns at the negedge after the CHECK->next edge.
  task automatic send_vec(input vec_t v);
    bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (i == v.gap_at) begin
        bus.key_ack = 1'b0;
        repeat (v.gap_len) @(negedge CK);
      end
      bus.key_ack = 1'b1;
      bus.key_bit = v.key[i];
      @(negedge CK);
    end
`ifdef KEY_LOAD_PARITY_EN
    bus.key_ack = 1'b1;
    bus.key_bit = (^v.key) ^ v.par_flip;
    @(negedge CK);
`endif
    bus.key_ack = 1'b0;
    bus.key_bit = 1'b0;
    @(negedge CK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] k96;
    logic [7:0] k29;
    k96 = 8'h96;
    k29 = 8'h29;
    bus.start   = 1'b0;
    bus.key_ack = 1'b0;
    bus.key_bit = 1'b0;
    RN = 1'b0;
    repeat (2) @(negedge CK);
    chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    RN = 1'b1;
    @(negedge CK);

    // Stray acks while idle must not start anything.
    bus.key_ack = 1'b1;
    bus.key_bit = 1'b1;
    repeat (3) @(negedge CK);
    chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.key_ack = 1'b0;

    //          key    gap_at gap_len flip done  err   key
    vecs.push_back('{8'h4D, -1, 0, 1'b0, 1'b1, 1'b0, 8'h4D});
    vecs.push_back('{8'hA5,  3, 4, 1'b0, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{8'h3C,  3, 3, 1'b0, 1'b1, 1'b0, 8'h3C});
    vecs.push_back('{8'hFF,  0, 2, 1'b0, 1'b1, 1'b0, 8'hFF});
    vecs.push_back('{8'h00, -1, 0, 1'b0, 1'b1, 1'b0, 8'h00});
    vecs.push_back('{8'h81,  7, 4, 1'b0, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{8'h5A,  0, 4, 1'b0, 1'b0, 1'b1, 8'h00});
    vecs.push_back('{8'h6E,  5, 3, 1'b0, 1'b1, 1'b0, 8'h6E});
`ifdef KEY_LOAD_PARITY_EN
    vecs.push_back('{8'hA5, -1, 0, 1'b0, 1'b1, 1'b0, 8'hA5});
    vecs.push_back('{8'hA5, -1, 0, 1'b1, 1'b0, 1'b1, 8'h00});
`endif
    vecs.push_back('{8'hC3, -1, 0, 1'b0, 1'b1, 1'b0, 8'hC3});

    foreach (vecs[n]) begin
      send_vec(vecs[n]);
      chk_outs($sformatf("vec%0d", n), 1'b0, 1'b0, vecs[n].exp_done,
               vecs[n].exp_done, vecs[n].exp_err, vecs[n].exp_key);
    end

    // Reload from ARMED: key drops at once, start pulses during LOAD are ignored.
    bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    chk_outs("reload_entry", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < KW; i++) begin
      bus.key_ack = 1'b1;
      bus.key_bit = k96[i];
      bus.start   = (i == 2) || (i == 5);
      @(negedge CK);
      if (i == 4) chk_outs("reload_partial", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    end
    bus.start = 1'b0;
`ifdef KEY_LOAD_PARITY_EN
    bus.key_ack = 1'b1;
    bus.key_bit = ^k96;
    @(negedge CK);
`endif
    bus.key_ack = 1'b0;
    @(negedge CK);
    chk_outs("reload_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96);

    // Reset after 5 of 8 bits (all ones), then a fresh load.
    bus.start = 1'b1;
    @(negedge CK);
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.key_ack = 1'b1;
      bus.key_bit = 1'b1;
      @(negedge CK);
    end
    bus.key_ack = 1'b0;
    #2 RN = 1'b0;
    #1 chk_outs("midload_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    chk_outs("post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    send_vec('{k29, -1, 0, 1'b0, 1'b1, 1'b0, k29});
    chk_outs("post_reset_key", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h29);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_load_ctrl.md
# key_load_ctrl

Sequencer that loads the logic-locking key for an obfuscated benchmark core from an external key store over a bit-serial request/acknowledge handshake. It holds the locked core disabled with an all-zero key until a complete key has been received and checked, then applies the whole key atomically and enables the core. It sits between the key store and the `keyinput` bus plus clock-enable of the locked netlist.

## Interface
Parameters:
- `KEY_W`, 32, width of the key bus driven to the locked core (≥1).
- `TIMEOUT`, 255, maximum idle cycles waiting for `key_ack` before aborting (≥1).

Ports:
- `CK`  in  1  clock; all state updates on the rising edge.
- `RN`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse requesting a (re)load.
- `key_req`  out  1  request for the next key bit.
- `key_ack`  in  1  key store: `key_bit` valid this cycle.
- `key_bit`  in  1  serial key data.
- `keyinput`  out  KEY_W  key applied to the locked core.
- `core_en`  out  1  enable for the locked core.
- `busy`  out  1  load in progress.
- `done`  out  1  key applied; high while ARMED.
- `err`  out  1  load aborted; high while ERROR.

## Operation
- States: IDLE, LOAD, CHECK, ARMED, ERROR.
- Reset (any state, asynchronous): IDLE; `keyinput`=0, `core_en`=0, `key_req`=0, `busy`=0, `done`=0, `err`=0; bit counter, timeout counter and shadow register cleared.
- IDLE: `start`=1 → LOAD.
- LOAD: `key_req`=1, `busy`=1. Each cycle with `key_ack`=1 accepts one bit: `shadow <= {key_bit, shadow[KEY_W-1:1]}`. The first received bit ends up in `keyinput[0]`, the last in `keyinput[KEY_W-1]`. The bit counter increments once per accepted bit. After bit KEY_W is accepted → CHECK.
- Timeout: the counter resets on every accepted bit and increments on every LOAD cycle without `key_ack`. When it reaches TIMEOUT → ERROR.
- CHECK: single cycle, `key_req`=0 (parity variant: see Configuration). On pass → ARMED, and `keyinput <= shadow` in the same edge.
- ARMED: `core_en`=1, `done`=1, and `keyinput` is stable. `start` → LOAD; `keyinput` clears to 0 and `core_en` drops on that same edge.
- ERROR: `err`=1, `keyinput`=0, `core_en`=0. `start` → LOAD.
- `start` is ignored while in LOAD or CHECK.
- `key_ack` outside LOAD is ignored.
- The shadow register and bit counter clear on every entry to LOAD.
- `keyinput` never exposes a partial key; it is either 0 or a fully checked key.

## Timing
- `start` sampled at edge n: `key_req`=1 and `busy`=1 from cycle n+1.
- With `key_ack` held high, bit KEY_W is accepted at edge n+KEY_W, which enters CHECK. ARMED and a valid `keyinput` follow at edge n+KEY_W+1. Minimum latency is KEY_W+1 cycles (KEY_W+2 with parity).
- All outputs are registered; no combinational path from inputs to outputs.
- Timeout fires on the edge where the consecutive no-ack count equals TIMEOUT; `err` is high the next cycle.
- `key_ack` with timeout expiry in the same cycle: the bit is accepted and no timeout occurs.
- Reset mid-LOAD aborts immediately; partial key data is discarded.

## Configuration
- `KEY_LOAD_PARITY_EN` defined:
  - After KEY_W data bits, LOAD continues for one extra handshake beat carrying an even-parity bit over the key.
  - CHECK compares this bit with the XOR of the shadow register. Mismatch → ERROR with `keyinput` still 0; match → ARMED.
- Undefined: no parity beat; CHECK always passes.

## Structure
- Package `key_load_pkg`:
  - state enum `kl_state_t`;
  - default constants `KL_KEY_W_DEF`=32 and `KL_TIMEOUT_DEF`=255;
  - width function `kl_cnt_w(n)` = $clog2(n+1), used to size the bit and timeout counters.
- Sub-module `key_shift_reg`: KEY_W shadow shift register with clear, shift-enable, running parity, and a parallel output.
- FSM, counters and the output register stay in `key_load_ctrl`.

## Test plan
- Reset then idle: `RN` low mid-run → all outputs 0 within the reset cycle; no `key_req` without `start`.
- KEY_W=8, `key_ack` constantly 1, bits 1,0,1,1,0,0,1,0 → `keyinput`=8'b01001101, `done`=1 nine cycles after `start`.
- Ack withheld for TIMEOUT=4 cycles after bit 3 → `err`=1, `keyinput`=0; then `start` with a full key → ARMED.
- Reload: `start` in ARMED → `core_en`=0 and `keyinput`=0 next cycle; new key applied after reload completes; `start` pulses during LOAD have no effect.
- Parity build: key 8'hA5 with parity 0 → ARMED; same key with parity 1 → ERROR, `keyinput` stays 0.
- Reset asserted after bit 5 of 8, then a fresh `start` → the completed key contains only the post-reset bits.
